// File: rtl/add_serial_pkg.sv
// Shared definitions for the bit-serial adder sequencer and its result FIFO.
package add_serial_pkg;
  localparam int ADD_W        = 8;
  localparam int ADD_LAT_DFLT = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } seq_state_e;
endpackage

// File: rtl/add_serial_seq_if.sv
// Operand stream, add_serial pin bundle and result stream of the sequencer.
interface add_serial_seq_if #(
  parameter int TAG_W = 4
);
  logic                             in_valid;
  logic                             in_ready;
  logic [add_serial_pkg::ADD_W-1:0] in_a;
  logic [add_serial_pkg::ADD_W-1:0] in_b;
  logic                             add_en;
  logic [add_serial_pkg::ADD_W-1:0] add_a;
  logic [add_serial_pkg::ADD_W-1:0] add_b;
  logic [add_serial_pkg::ADD_W-1:0] add_out;
  logic                             res_valid;
  logic                             res_ready;
  logic [add_serial_pkg::ADD_W-1:0] res_data;
  logic [TAG_W-1:0]                 res_tag;
  logic                             busy;

  modport master (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_en, add_a, add_b, res_valid, res_data, res_tag, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_en, add_a, add_b, res_valid, res_data, res_tag, busy
  );
endinterface

// File: rtl/add_serial_res_fifo.sv
// Small synchronous result FIFO; head entry is presented combinationally.
module add_serial_res_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/add_serial_seq.sv
// Launches one add_serial operation at a time, waits out its serial latency,
// and queues tagged sums for a downstream consumer.
module add_serial_seq
  import add_serial_pkg::*;
#(
  parameter int ADD_LAT = ADD_LAT_DFLT,
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4
) (
  input logic             clk,
  input logic             rst,
  add_serial_seq_if.slave bus
);
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = ADD_W + TAG_W;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             add_en_q, add_en_d;
  logic [ADD_W-1:0] add_a_q, add_a_d;
  logic [ADD_W-1:0] add_b_q, add_b_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  logic [ENT_W-1:0] fifo_head;
  logic             in_ready;

  assign in_ready = !rst && (state_q == ST_IDLE) && (fifo_count < (AW+1)'(DEPTH));

  // add_en spans the handshake-registered cycle and the LAUNCH cycle, so the
  // adder is guaranteed to observe en while it sits in its own IDLE.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    tag_d      = tag_q;
    add_en_d   = 1'b0;
    add_a_d    = add_a_q;
    add_b_d    = add_b_q;
    fifo_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && in_ready) begin
          add_a_d  = bus.in_a;
          add_b_d  = bus.in_b;
          add_en_d = 1'b1;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        add_en_d   = 1'b1;
        wait_cnt_d = CNT_W'(1);
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        if (wait_cnt_q == CNT_W'(ADD_LAT - 1)) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        fifo_push  = !fifo_full;
        tag_d      = tag_q + TAG_W'(1);
        wait_cnt_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      tag_q      <= '0;
      add_en_q   <= 1'b0;
      add_a_q    <= '0;
      add_b_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
      add_en_q   <= add_en_d;
      add_a_q    <= add_a_d;
      add_b_q    <= add_b_d;
    end
  end

  assign fifo_pop = !fifo_empty && bus.res_ready;

  add_serial_res_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({bus.add_out, tag_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.in_ready  = in_ready;
  assign bus.add_en    = add_en_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_valid = !fifo_empty;
  assign bus.res_data  = fifo_head[TAG_W +: ADD_W];
  assign bus.res_tag   = fifo_head[TAG_W-1:0];
  assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_add_serial_seq.sv
// Scoreboard bench for add_serial_seq with a behavioural bit-serial adder partner.
module tb_add_serial_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  add_serial_seq_if #(.TAG_W(4)) bus ();

  add_serial_seq #(.ADD_LAT(9), .DEPTH(4), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Behavioural add_serial: load on en in IDLE, 8 LSB-first serial steps, DONE until en low.
  logic [1:0] ad_st;
  logic [7:0] ad_a, ad_b, ad_out;
  logic       ad_c;
  int         ad_cnt;
  assign bus.add_out = ad_out;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_st <= 2'd0; ad_out <= 8'h00; ad_a <= 8'h00; ad_b <= 8'h00; ad_c <= 1'b0; ad_cnt <= 0;
    end else begin
      case (ad_st)
        2'd0: if (bus.add_en) begin
          ad_a <= bus.add_a; ad_b <= bus.add_b; ad_c <= 1'b0; ad_cnt <= 0; ad_st <= 2'd1;
        end
        2'd1: begin
          ad_out <= {ad_a[0] ^ ad_b[0] ^ ad_c, ad_out[7:1]};
          ad_c   <= (ad_a[0] & ad_b[0]) | (ad_c & (ad_a[0] ^ ad_b[0]));
          ad_a   <= ad_a >> 1;
          ad_b   <= ad_b >> 1;
          ad_cnt <= ad_cnt + 1;
          if (ad_cnt == 7) ad_st <= 2'd2;
        end
        default: if (!bus.add_en) ad_st <= 2'd0;
      endcase
    end
  end

  typedef struct packed { logic [7:0] data; logic [3:0] tag; } exp_t;
  exp_t       exp_q[$];
  logic [3:0] exp_tag = 4'd0;
  int         n_checks = 0;
  int         n_errs   = 0;
  int         cyc      = 0;
  int         hs_cyc   = 0;
  bit         track_cnt = 1'b0;
  int         max_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every result transfer is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errs++;
        $display("FAIL unexpected_result: got data 0x%0h tag %0d with no result expected",
                 bus.res_data, bus.res_tag);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_data", 32'(bus.res_data), 32'(e.data));
        chk("res_tag",  32'(bus.res_tag),  32'(e.tag));
      end
    end
    if (track_cnt && int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
  end

  // Handshake one operand pair; push the expected result only when it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit expect_result);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        got    = 1'b1;
        hs_cyc = cyc;
        if (expect_result) begin
          exp_q.push_back({a + b, exp_tag});
          exp_tag = exp_tag + 4'd1;
        end
      end
    end
    if (!got) begin
      n_checks++; n_errs++;
      $display("FAIL handshake_timeout: in_ready never high for a=0x%0h b=0x%0h", a, b);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || bus.busy); i++) @(negedge clk);
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_tag = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cnt;
    int rv_at;
    int rdy_seen;
    bus.in_valid  = 1'b0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.res_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_add_en",    32'(bus.add_en),    32'd0);
    chk("rst_add_a",     32'(bus.add_a),     32'd0);
    chk("rst_add_b",     32'(bus.add_b),     32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_data",  32'(bus.res_data),  32'd0);
    chk("rst_res_tag",   32'(bus.res_tag),   32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Single add with latency and add_en pulse width
    send(8'h3C, 8'h5A, 1'b1);
    en_cnt = 0; rv_at = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.add_en) en_cnt++;
      if (k == 4) chk("add_a_held", 32'(bus.add_a), 32'h3C);
      if (bus.res_valid && rv_at < 0) rv_at = cyc - hs_cyc;
    end
    chk("add_en_cycles", 32'(en_cnt), 32'd2);
    chk("res_latency",   32'(rv_at),  32'd11);
    drain("drain_single");

    // Overflow wrap
    send(8'hFF, 8'h01, 1'b1);
    send(8'h80, 8'h80, 1'b1);
    send(8'h7F, 8'h01, 1'b1);
    drain("drain_wrap");

    // FIFO full: four results held, fifth pair blocked until space frees
    do_reset();
    bus.res_ready = 1'b0;
    send(8'h01, 8'h02, 1'b1);
    send(8'h10, 8'h20, 1'b1);
    send(8'hA0, 8'h0B, 1'b1);
    send(8'hC3, 8'h3C, 1'b1);
    for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
    rdy_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.in_ready) rdy_seen++;
    end
    chk("full_in_ready_low", 32'(rdy_seen), 32'd0);
    chk("full_res_valid",    32'(bus.res_valid), 32'd1);
    chk("full_head_tag",     32'(bus.res_tag),   32'd0);
    bus.res_ready = 1'b1;
    send(8'h11, 8'h22, 1'b1);
    chk("fifth_tag_pushed", 32'(exp_tag), 32'd5);
    drain("drain_full");

    // Back-to-back with continuous drain; tags wrap past 15
    track_cnt = 1'b1; max_cnt = 0;
    for (int i = 0; i < 20; i++) send(8'(i * 37 + 3), 8'(i * 91 + 250), 1'b1);
    drain("drain_b2b");
    track_cnt = 1'b0;
    chk("b2b_max_count", 32'(max_cnt), 32'd1);

    // Reset in WAIT cycle 5 discards the in-flight add
    send(8'h12, 8'h34, 1'b0);
    while (cyc < hs_cyc + 6) @(negedge clk);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_add_en",    32'(bus.add_en),    32'd0);
    chk("midrst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("midrst_busy",      32'(bus.busy),      32'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    exp_tag = 4'd0;
    send(8'h55, 8'h66, 1'b1);
    drain("drain_after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/add_serial_seq.md
Name: add_serial_seq

Overview:
- Operand sequencer and result collector for the bit-serial 8-bit adder `add_serial`.
- Accepts operand pairs on a valid/ready stream and drives the adder's `a`/`b`/`en` pins. Waits a fixed serial latency, then captures the adder's `out` into a small result FIFO that drains on a second valid/ready stream.
- Exactly one add in flight at a time. Each result carries a wrap-around sequence tag.

Parameters:
- `ADD_LAT`, 9, cycles from the `add_en` launch edge to the first cycle `add_out` is valid (1 load + 8 serial bits).
- `DEPTH`, 4, result FIFO entries (power of two, ≥2).
- `TAG_W`, 4, sequence tag width.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  sequencer can accept an operand pair
- `in_a`  in  8  operand A
- `in_b`  in  8  operand B
- `add_en`  out  1  enable to `add_serial`
- `add_a`  out  8  operand A to `add_serial`
- `add_b`  out  8  operand B to `add_serial`
- `add_out`  in  8  result from `add_serial`
- `res_valid`  out  1  FIFO head valid
- `res_ready`  in  1  consumer takes FIFO head
- `res_data`  out  8  FIFO head sum
- `res_tag`  out  TAG_W  FIFO head sequence tag
- `busy`  out  1  add in flight (state != IDLE)

Behaviour:
- Reset values: `add_en`=0, `add_a`=0, `add_b`=0, `in_ready`=0 during reset, FIFO empty, `res_valid`=0, `res_data`=0, `res_tag`=0, tag counter=0, state=IDLE, wait counter=0, `busy`=0.
- `in_ready` = (state==IDLE) && (fifo_count < DEPTH). Combinational from registered state only; it does not depend on `res_ready`.
- States:
  - **IDLE**: on `in_valid && in_ready`, register `in_a`/`in_b` into `add_a`/`add_b` and set `add_en`=1. Next state LAUNCH.
  - **LAUNCH**: one cycle, `add_en`=1, so the adder sees `en` high in its IDLE.
    - Next cycle: `add_en`=0, wait counter=1, state WAIT.
  - **WAIT**: counter increments each cycle. When counter==ADD_LAT-1, go to CAPTURE.
    - `add_en` stays 0 throughout, so the adder returns from DONE to IDLE.
  - **CAPTURE**: one cycle. Push {`add_out`, tag} into the FIFO, increment the tag (mod 2^TAG_W), go to IDLE.
- `add_a`/`add_b` are held stable from LAUNCH through CAPTURE and hold their value in IDLE.
- Latency: operand handshake at cycle 0 → `add_en` high in cycles 1–2 → capture in cycle ADD_LAT+1 → `res_valid` in cycle ADD_LAT+2. This is 11 cycles with defaults.
  - With back-to-back requests, the next `in_ready` is in cycle ADD_LAT+2.
- The FIFO never overflows: acceptance requires a free slot, and only one add is in flight.
- FIFO:
  - Pop when `res_valid && res_ready`.
  - Push and pop in the same cycle: count unchanged, data ordering preserved.
  - Push into an empty FIFO: `res_valid` rises the next cycle. There is no same-cycle bypass.
  - `res_data`/`res_tag` show the head entry and hold while `res_valid` is low.
- Tag wraps from 2^TAG_W-1 to 0.
- Sum is 8-bit modulo 256; no carry-out is reported.
- `rst` asserted mid-operation: state, FIFO and tag clear immediately. The in-flight result is discarded and `add_en` drops at once.
- `in_valid` while `in_ready`=0: ignored. Upstream holds its data.

Decomposition:
- Shared package `add_serial_pkg`:
  - state enum (IDLE, LAUNCH, WAIT, CAPTURE)
  - `ADD_W`=8
  - default `ADD_LAT`=9
- Sub-module `add_serial_res_fifo`: synchronous FIFO with parameters DEPTH and width 8+TAG_W, and ports push, pop, full, empty, count.
- The sequencer FSM and wait counter live in the top module.

Test Plan:
- Single add, `add_serial` instantiated as the DUT partner: 0x3C+0x5A → `res_data`=0x96, `res_tag`=0, `res_valid` rises exactly 11 cycles after the operand handshake; `add_en` is high exactly 2 cycles.
- Overflow wrap: 0xFF+0x01 → 0x00; 0x80+0x80 → 0x00; 0x7F+0x01 → 0x80.
- FIFO full: `res_ready`=0, issue 5 pairs → 4 accepted, `in_ready` stays 0 after the 4th capture. Raise `res_ready` → results pop in order with tags 0,1,2,3, then the 5th pair is accepted and gets tag 4.
- Simultaneous push/pop: `res_ready`=1 continuously, 20 back-to-back pairs → FIFO count never exceeds 1, tags wrap 15→0, every sum correct.
- Reset mid-op: assert `rst` in WAIT cycle 5 → `add_en`=0, `res_valid`=0 and `busy`=0 immediately. The next add after release returns the correct sum with tag 0.
